bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
- REQ-001 SHALL have parameter ADDR_W, default 10: RAM address width.
- REQ-002 SHALL have parameter DATA_W, default 16: RAM data width.
- REQ-003 SHALL have parameter RAM_LATENCY, default 1: RAM read latency in cycles; legal values are 1 (LOW_LATENCY) or 2 (HIGH_PERFORMANCE).
- REQ-004 SHALL have port clk_in, input, 1 bit: the single clock, rising-edge.
- REQ-005 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
- REQ-006 SHALL have, for each N in {0,1}, port reqN_valid, input, 1 bit: requester N presents a transfer.
- REQ-007 SHALL have reqN_ready, output, 1 bit: transfer accepted this cycle.
- REQ-008 SHALL have reqN_we, input, 1 bit: 1 = write, 0 = read.
- REQ-009 SHALL have reqN_addr, input, ADDR_W bits: word address.
- REQ-010 SHALL have reqN_wdata, input, DATA_W bits: write data.
- REQ-011 SHALL have rspN_valid, output, 1 bit: a response for requester N is present this cycle.
- REQ-012 SHALL have rspN_data, output, DATA_W bits: RAM contents read for the transfer.
- REQ-013 SHALL have ram_addr, output, ADDR_W bits, and ram_din, output, DATA_W bits: RAM port address and write data.
- REQ-014 SHALL have ram_en, output, 1 bit, and ram_we, output, 1 bit: RAM enable and write enable.
- REQ-015 SHALL have ram_regce, output, 1 bit, and ram_rst, output, 1 bit: RAM output-register enable and output-register reset.
- REQ-016 SHALL have ram_dout, input, DATA_W bits: RAM read data, read-first.

Function
- REQ-017 SHALL accept at most one transfer per cycle; a transfer is accepted when reqN_valid and reqN_ready are both 1.
- REQ-018 SHALL compute reqN_ready combinationally. It is 1 only for the granted requester. It never depends on reqN_ready of the other requester.
- REQ-019 SHALL grant a requester that is valid alone, regardless of priority.
- REQ-020 SHALL grant the requester named by a 1-bit priority pointer when both are valid.
- REQ-021 SHALL update the priority pointer to the non-granted index on every accepted transfer, and hold it otherwise. This gives strict alternation under contention, so the worst-case wait is 1 cycle.
- REQ-022 SHALL, in the acceptance cycle, drive ram_en=1, ram_we=reqN_we, ram_addr=reqN_addr and ram_din=reqN_wdata of the granted requester.
- REQ-023 SHALL drive ram_en=0 and ram_we=0 when no transfer is accepted; ram_addr and ram_din are then don't-care.
- REQ-024 SHALL produce exactly one response per accepted transfer, reads and writes alike. A write response carries the prior contents of the location (read-first behaviour).
- REQ-025 SHALL track in-flight transfers in a RAM_LATENCY-deep shift pipeline of {valid, id}. The pipeline advances every cycle with no stall.
- REQ-026 SHALL assert rspN_valid exactly RAM_LATENCY cycles after acceptance, for one cycle, with rspN_data=ram_dout.
- REQ-027 SHALL keep rspN_valid at 0 for the requester that does not own the response. rspN_data is then don't-care.
- REQ-028 SHALL deliver responses in acceptance order, since the fixed latency guarantees this. There is no response backpressure, and requesters must sink responses.
- REQ-029 SHALL, when RAM_LATENCY=2, drive ram_regce equal to the stage-1 pipeline valid. When RAM_LATENCY=1 it drives ram_regce=1.
- REQ-030 SHALL drive ram_rst=rst_in.
- REQ-031 SHALL allow back-to-back transfers every cycle from one or both requesters, including a read-after-write to the same address in consecutive cycles. In that case the read returns the newly written data.

Reset
- REQ-032 SHALL, while rst_in=1, drive reqN_ready=0, ram_en=0, ram_we=0 and rspN_valid=0.
- REQ-033 SHALL, on reset, set the priority pointer to 0 and clear all pipeline valids.
- REQ-034 SHALL discard transfers in flight when reset asserts mid-operation: no response is ever issued for them. The first grant after reset release may occur in the first cycle with rst_in=0.

Verification
- REQ-035 SHALL cover a single-requester write then read: req0 writes 0x1234 at addr 5, then reads addr 5. The read gives rsp0_valid after RAM_LATENCY cycles with rsp0_data=0x1234, and rsp1_valid stays 0.
- REQ-036 SHALL cover contention: both requesters valid for 4 cycles after reset. Grants are 0,1,0,1, and each ready is high on alternate cycles.
- REQ-037 SHALL cover the read-first write response: addr 7 holds 0x00AA, and req1 writes 0x0055 there. rsp1_data=0x00AA, and a later read returns 0x0055.
- REQ-038 SHALL cover the pointer after a lone grant: req1 is alone for 1 cycle, then both are valid. Req0 is granted next.
- REQ-039 SHALL cover reset mid-operation: rst_in is asserted in the cycle after a read is accepted. No rspN_valid appears for that read, and after release the first contention grant goes to req0.
- REQ-040 SHALL run scenarios REQ-035 to REQ-039 with RAM_LATENCY=1 and RAM_LATENCY=2. For RAM_LATENCY=2, ram_regce pulses exactly one cycle after each ram_en.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter sharing one BRAM port: alternating priority under
// contention and a fixed-latency pipeline that routes read data back to its owner.
module bram_port_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_regce,
  output logic              ram_rst,
  input  logic [DATA_W-1:0] ram_dout
);

  logic                   prio_q, prio_d;
  logic [RAM_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
  logic [RAM_LATENCY-1:0] pipe_id_q, pipe_id_d;
  logic                   accept;
  logic                   grant_id;

  // Each ready looks only at both valids and the pointer, never the other ready.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst_in) begin
      req0_ready = req0_valid && (!req1_valid || !prio_q);
      req1_ready = req1_valid && (!req0_valid || prio_q);
    end
  end

  assign accept   = req0_ready || req1_ready;
  assign grant_id = req1_ready;

  always_comb begin
    ram_en   = accept;
    ram_we   = accept && (grant_id ? req1_we : req0_we);
    ram_addr = grant_id ? req1_addr : req0_addr;
    ram_din  = grant_id ? req1_wdata : req0_wdata;
  end

  always_comb begin
    prio_d       = accept ? !grant_id : prio_q;
    pipe_valid_d = '0;
    pipe_id_d    = '0;
    pipe_valid_d[0] = accept;
    pipe_id_d[0]    = grant_id;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_id_d[i]    = pipe_id_q[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prio_q       <= 1'b0;
      pipe_valid_q <= '0;
      pipe_id_q    <= '0;
    end else begin
      prio_q       <= prio_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_id_q    <= pipe_id_d;
    end
  end

  // The last pipeline stage lines up with the cycle ram_dout carries the data.
  always_comb begin
    rsp0_valid = !rst_in && pipe_valid_q[RAM_LATENCY-1] && !pipe_id_q[RAM_LATENCY-1];
    rsp1_valid = !rst_in && pipe_valid_q[RAM_LATENCY-1] &&  pipe_id_q[RAM_LATENCY-1];
    rsp0_data  = ram_dout;
    rsp1_data  = ram_dout;
  end

  if (RAM_LATENCY == 2) begin : g_regce_pipe
    assign ram_regce = pipe_valid_q[0];
  end else begin : g_regce_const
    assign ram_regce = 1'b1;
  end

  assign ram_rst = rst_in;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: one instance per RAM latency, each with its own
// read-first BRAM model and an abstract grant/response reference model.
module tb_bram_port_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef struct {
    int                due;
    logic              id;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              req0_valid, req0_we, req1_valid, req1_we;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;

  logic              req0_ready_w [2];
  logic              req1_ready_w [2];
  logic              rsp0_valid_w [2];
  logic              rsp1_valid_w [2];
  logic [DATA_W-1:0] rsp0_data_w  [2];
  logic [DATA_W-1:0] rsp1_data_w  [2];
  logic [ADDR_W-1:0] ram_addr_w   [2];
  logic [DATA_W-1:0] ram_din_w    [2];
  logic              ram_en_w     [2];
  logic              ram_we_w     [2];
  logic              ram_regce_w  [2];
  logic              ram_rst_w    [2];
  logic [DATA_W-1:0] ram_dout_w   [2];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit mon_en      = 1'b0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = g + 1;
    logic [DATA_W-1:0] mem    [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_stage, out_reg;
    exp_t              exp_q [$];
    logic              prio_m, prev_acc;
    logic              m_r0, m_r1, m_acc, m_gid, m_we, m_v0, m_v1;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wd, m_d;

    bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LATENCY(LAT)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req0_valid(req0_valid), .req0_ready(req0_ready_w[g]), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid_w[g]), .rsp0_data(rsp0_data_w[g]),
      .req1_valid(req1_valid), .req1_ready(req1_ready_w[g]), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid_w[g]), .rsp1_data(rsp1_data_w[g]),
      .ram_addr(ram_addr_w[g]), .ram_din(ram_din_w[g]), .ram_en(ram_en_w[g]),
      .ram_we(ram_we_w[g]), .ram_regce(ram_regce_w[g]), .ram_rst(ram_rst_w[g]),
      .ram_dout(ram_dout_w[g])
    );

    initial begin
      for (int i = 0; i < (1<<ADDR_W); i++) begin
        mem[i]    = '0;
        shadow[i] = '0;
      end
      prio_m   = 1'b0;
      prev_acc = 1'b0;
      rd_stage = '0;
      out_reg  = '0;
    end

    // Read-first BRAM with optional output register
    always @(posedge clk_in) begin
      if (ram_en_w[g]) begin
        rd_stage <= mem[ram_addr_w[g]];
        if (ram_we_w[g]) mem[ram_addr_w[g]] <= ram_din_w[g];
      end
      if (ram_rst_w[g]) out_reg <= '0;
      else if (ram_regce_w[g]) out_reg <= rd_stage;
    end
    assign ram_dout_w[g] = (LAT == 2) ? out_reg : rd_stage;

    // Reference model: who wins, and which response is due in which cycle
    always @(negedge clk_in) begin
      if (mon_en) begin
        if (rst_in) begin
          m_r0 = 1'b0; m_r1 = 1'b0;
        end else if (req0_valid && req1_valid) begin
          m_r0 = (prio_m == 1'b0); m_r1 = (prio_m == 1'b1);
        end else begin
          m_r0 = req0_valid; m_r1 = req1_valid;
        end
        m_acc  = m_r0 || m_r1;
        m_gid  = m_r1;
        m_we   = m_gid ? req1_we : req0_we;
        m_addr = m_gid ? req1_addr : req0_addr;
        m_wd   = m_gid ? req1_wdata : req0_wdata;

        vectors++;
        if (req0_ready_w[g] !== m_r0) begin
          miscompares++;
          $display("[TB] FAIL req0_ready L=%0d cyc=%0d got %b want %b", LAT, cyc, req0_ready_w[g], m_r0);
        end
        vectors++;
        if (req1_ready_w[g] !== m_r1) begin
          miscompares++;
          $display("[TB] FAIL req1_ready L=%0d cyc=%0d got %b want %b", LAT, cyc, req1_ready_w[g], m_r1);
        end
        vectors++;
        if (ram_en_w[g] !== m_acc) begin
          miscompares++;
          $display("[TB] FAIL ram_en L=%0d cyc=%0d got %b want %b", LAT, cyc, ram_en_w[g], m_acc);
        end
        vectors++;
        if (ram_we_w[g] !== (m_acc && m_we)) begin
          miscompares++;
          $display("[TB] FAIL ram_we L=%0d cyc=%0d got %b want %b", LAT, cyc, ram_we_w[g], m_acc && m_we);
        end
        if (m_acc) begin
          vectors++;
          if (ram_addr_w[g] !== m_addr || (m_we && ram_din_w[g] !== m_wd)) begin
            miscompares++;
            $display("[TB] FAIL ram_addr_din L=%0d cyc=%0d got %h/%h want %h/%h",
                     LAT, cyc, ram_addr_w[g], ram_din_w[g], m_addr, m_wd);
          end
        end

        m_v0 = 1'b0; m_v1 = 1'b0; m_d = '0;
        if (!rst_in && exp_q.size() > 0 && exp_q[0].due == cyc) begin
          m_v0 = !exp_q[0].id;
          m_v1 =  exp_q[0].id;
          m_d  =  exp_q[0].data;
          exp_q.delete(0);
        end
        vectors++;
        if (rsp0_valid_w[g] !== m_v0 || rsp1_valid_w[g] !== m_v1) begin
          miscompares++;
          $display("[TB] FAIL rsp_valid L=%0d cyc=%0d got %b%b want %b%b",
                   LAT, cyc, rsp1_valid_w[g], rsp0_valid_w[g], m_v1, m_v0);
        end
        if (m_v0 || m_v1) begin
          vectors++;
          if ((m_v0 ? rsp0_data_w[g] : rsp1_data_w[g]) !== m_d) begin
            miscompares++;
            $display("[TB] FAIL rsp_data L=%0d cyc=%0d got %h want %h", LAT, cyc,
                     m_v0 ? rsp0_data_w[g] : rsp1_data_w[g], m_d);
          end
        end
        vectors++;
        if (ram_regce_w[g] !== ((LAT == 2) ? prev_acc : 1'b1)) begin
          miscompares++;
          $display("[TB] FAIL ram_regce L=%0d cyc=%0d got %b want %b", LAT, cyc,
                   ram_regce_w[g], (LAT == 2) ? prev_acc : 1'b1);
        end
        vectors++;
        if (ram_rst_w[g] !== rst_in) begin
          miscompares++;
          $display("[TB] FAIL ram_rst L=%0d cyc=%0d got %b want %b", LAT, cyc, ram_rst_w[g], rst_in);
        end

        if (rst_in) begin
          exp_q.delete();
          prio_m   = 1'b0;
          prev_acc = 1'b0;
        end else begin
          if (m_acc) begin
            exp_q.push_back('{due: cyc + LAT, id: m_gid, data: shadow[m_addr]});
            if (m_we) shadow[m_addr] = m_wd;
            prio_m = !m_gid;
          end
          prev_acc = m_acc;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic idle(input int n);
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    drive0(1'b1, 1'b1, 10'd1, 16'h1111);
    drive1(1'b1, 1'b1, 10'd2, 16'h2222);
    next_cycle();
    mon_en = 1'b1;
    repeat (2) begin
      @(negedge clk_in);
      for (int g = 0; g < 2; g++) begin
        vectors++;
        if (req0_ready_w[g] !== 1'b0 || req1_ready_w[g] !== 1'b0 || ram_en_w[g] !== 1'b0 ||
            ram_we_w[g] !== 1'b0 || rsp0_valid_w[g] !== 1'b0 || rsp1_valid_w[g] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL reset_outputs L=%0d got rdy=%b%b en=%b we=%b rsp=%b%b want all 0", g + 1,
                   req1_ready_w[g], req0_ready_w[g], ram_en_w[g], ram_we_w[g],
                   rsp1_valid_w[g], rsp0_valid_w[g]);
        end
      end
      next_cycle();
    end
    rst_in = 1'b0;
    idle(1);
  endtask

  task automatic test_write_read();
    drive0(1'b1, 1'b1, 10'd5, 16'h1234);
    next_cycle();
    idle(3);
    drive0(1'b1, 1'b0, 10'd5, 16'h0000);
    next_cycle();
    drive0(1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_in);
      for (int g = 0; g < 2; g++) begin
        vectors++;
        if (rsp0_valid_w[g] !== (k == g + 1) || rsp1_valid_w[g] !== 1'b0 ||
            (k == g + 1 && rsp0_data_w[g] !== 16'h1234)) begin
          miscompares++;
          $display("[TB] FAIL write_read L=%0d k=%0d got v=%b%b d=%h want v0=%b d=1234", g + 1, k,
                   rsp1_valid_w[g], rsp0_valid_w[g], rsp0_data_w[g], k == g + 1);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_contention();
    rst_in = 1'b1;
    next_cycle();
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b0, 10'(i), '0);
      drive1(1'b1, 1'b0, 10'(i + 8), '0);
      @(negedge clk_in);
      for (int g = 0; g < 2; g++) begin
        vectors++;
        if (req0_ready_w[g] !== (i % 2 == 0) || req1_ready_w[g] !== (i % 2 == 1)) begin
          miscompares++;
          $display("[TB] FAIL contention L=%0d i=%0d got rdy=%b%b want rdy0=%b", g + 1, i,
                   req1_ready_w[g], req0_ready_w[g], i % 2 == 0);
        end
      end
      next_cycle();
    end
    idle(3);
  endtask

  task automatic test_read_first();
    drive0(1'b1, 1'b1, 10'd7, 16'h00AA);
    next_cycle();
    idle(3);
    drive1(1'b1, 1'b1, 10'd7, 16'h0055);
    next_cycle();
    drive1(1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_in);
      for (int g = 0; g < 2; g++) begin
        vectors++;
        if (rsp1_valid_w[g] !== (k == g + 1) || rsp0_valid_w[g] !== 1'b0 ||
            (k == g + 1 && rsp1_data_w[g] !== 16'h00AA)) begin
          miscompares++;
          $display("[TB] FAIL read_first_wr L=%0d k=%0d got v=%b%b d=%h want v1=%b d=00aa", g + 1, k,
                   rsp1_valid_w[g], rsp0_valid_w[g], rsp1_data_w[g], k == g + 1);
        end
      end
      next_cycle();
    end
    drive1(1'b1, 1'b0, 10'd7, '0);
    next_cycle();
    drive1(1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_in);
      for (int g = 0; g < 2; g++) begin
        vectors++;
        if (rsp1_valid_w[g] !== (k == g + 1) || (k == g + 1 && rsp1_data_w[g] !== 16'h0055)) begin
          miscompares++;
          $display("[TB] FAIL read_first_rd L=%0d k=%0d got v=%b d=%h want v=%b d=0055", g + 1, k,
                   rsp1_valid_w[g], rsp1_data_w[g], k == g + 1);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_lone_grant();
    drive0(1'b1, 1'b0, 10'd1, '0);
    @(negedge clk_in);
    next_cycle();
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b1, 1'b0, 10'd2, '0);
    @(negedge clk_in);
    for (int g = 0; g < 2; g++) begin
      vectors++;
      if (req1_ready_w[g] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL lone_req1 L=%0d got %b want 1", g + 1, req1_ready_w[g]);
      end
    end
    next_cycle();
    drive0(1'b1, 1'b0, 10'd3, '0);
    drive1(1'b1, 1'b0, 10'd4, '0);
    @(negedge clk_in);
    for (int g = 0; g < 2; g++) begin
      vectors++;
      if (req0_ready_w[g] !== 1'b1 || req1_ready_w[g] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL lone_then_both L=%0d got rdy=%b%b want 01", g + 1,
                 req1_ready_w[g], req0_ready_w[g]);
      end
    end
    next_cycle();
    idle(3);
  endtask

  task automatic test_back_to_back();
    drive0(1'b1, 1'b1, 10'd3, 16'hBEEF);
    next_cycle();
    drive0(1'b1, 1'b0, 10'd3, '0);
    next_cycle();
    drive0(1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk_in);
      for (int g = 0; g < 2; g++) begin
        if (k == g + 1) begin
          vectors++;
          if (rsp0_valid_w[g] !== 1'b1 || rsp0_data_w[g] !== 16'hBEEF) begin
            miscompares++;
            $display("[TB] FAIL raw_b2b L=%0d got v=%b d=%h want v=1 d=beef", g + 1,
                     rsp0_valid_w[g], rsp0_data_w[g]);
          end
        end
      end
      next_cycle();
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    drive0(1'b1, 1'b0, 10'd5, '0);
    next_cycle();
    drive0(1'b0, 1'b0, '0, '0);
    rst_in = 1'b1;
    repeat (2) begin
      @(negedge clk_in);
      for (int g = 0; g < 2; g++) begin
        vectors++;
        if (rsp0_valid_w[g] !== 1'b0 || rsp1_valid_w[g] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL reset_mid_rsp L=%0d got %b%b want 00", g + 1,
                   rsp1_valid_w[g], rsp0_valid_w[g]);
        end
      end
      next_cycle();
    end
    rst_in = 1'b0;
    drive0(1'b1, 1'b0, 10'd6, '0);
    drive1(1'b1, 1'b0, 10'd9, '0);
    @(negedge clk_in);
    for (int g = 0; g < 2; g++) begin
      vectors++;
      if (req0_ready_w[g] !== 1'b1 || req1_ready_w[g] !== 1'b0 || rsp0_valid_w[g] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_grant L=%0d got rdy=%b%b rsp0=%b want rdy=01 rsp0=0", g + 1,
                 req1_ready_w[g], req0_ready_w[g], rsp0_valid_w[g]);
      end
    end
    next_cycle();
    idle(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive0($urandom_range(9) < 7, $urandom_range(1) == 1, ADDR_W'($urandom_range(7)), DATA_W'($urandom));
      drive1($urandom_range(9) < 7, $urandom_range(1) == 1, ADDR_W'($urandom_range(7)), DATA_W'($urandom));
      next_cycle();
    end
    idle(4);
  endtask

  initial begin
    rst_in = 1'b1;
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    test_reset();
    test_write_read();
    test_contention();
    test_read_first();
    test_lone_grant();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
